// File: rtl/instr_state_tag_array.sv
// N-way set-associative {state, tag} store for the I-Cache: registered lookup with
// hit/victim reporting, round-robin replacement and a hardware flash-invalidate sweep.

module instr_state_tag_way #(
  parameter int SET_WIDTH   = 4,
  parameter int TAG_WIDTH   = 22,
  parameter int STATE_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [SET_WIDTH-1:0]           wset,
  input  logic [STATE_WIDTH+TAG_WIDTH-1:0] wdata,
  input  logic [SET_WIDTH-1:0]           rset,
  input  logic [TAG_WIDTH-1:0]           rtag,
  output logic                           hit,
  output logic                           inval,
  output logic [STATE_WIDTH-1:0]         state
);
  localparam int EW = STATE_WIDTH + TAG_WIDTH;
  localparam logic [STATE_WIDTH-1:0] ST_I = STATE_WIDTH'(2'b10);

  logic [EW-1:0] mem [2**SET_WIDTH];
  logic [EW-1:0] rd;

  // Contents are not reset; the sweep is what makes them valid.
  always_ff @(posedge clk) begin
    if (we) mem[wset] <= wdata;
  end

  // Read returns the pre-edge contents, so a same-cycle write is not visible.
  assign rd    = mem[rset];
  assign state = rd[EW-1:TAG_WIDTH];
  assign inval = (state == ST_I);
  assign hit   = !inval && (rd[TAG_WIDTH-1:0] == rtag);
endmodule

module instr_state_tag_array #(
  parameter int SET_WIDTH   = 4,
  parameter int TAG_WIDTH   = 22,
  parameter int STATE_WIDTH = 2,
  parameter int NUM_WAYS    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [SET_WIDTH-1:0]             req_set,
  input  logic [TAG_WIDTH-1:0]             req_tag,
  output logic                             rsp_valid,
  output logic                             rsp_hit,
  output logic [NUM_WAYS-1:0]              rsp_hit_way,
  output logic [STATE_WIDTH-1:0]           rsp_state,
  output logic [NUM_WAYS-1:0]              rsp_victim_way,
  input  logic                             w_en,
  input  logic                             w_fill,
  input  logic [SET_WIDTH-1:0]             w_set,
  input  logic [NUM_WAYS-1:0]              w_way,
  input  logic [STATE_WIDTH+TAG_WIDTH-1:0] w_state_tag,
  input  logic                             inv_all,
  output logic                             busy
);
  localparam int NSETS = 2**SET_WIDTH;
  localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [STATE_WIDTH-1:0] ST_I     = STATE_WIDTH'(2'b10);
  localparam logic [SET_WIDTH-1:0]   LAST_SET = '1;
  localparam logic [0:0] S_SWEEP = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  typedef struct packed {
    logic                   hit;
    logic [NUM_WAYS-1:0]    hit_way;
    logic [STATE_WIDTH-1:0] state;
    logic [NUM_WAYS-1:0]    victim;
  } rsp_t;

  logic [0:0]                      fsm_q, fsm_d;
  logic [SET_WIDTH-1:0]            cnt_q, cnt_d;
  logic [NSETS-1:0][PTR_W-1:0]     ptr_q, ptr_d;
  rsp_t                            rsp_q, rsp_d;
  logic                            rsp_valid_q, rsp_valid_d;

  logic                            accept, wr_ok;
  logic [NUM_WAYS-1:0]             way_hit, way_inval;
  logic [NUM_WAYS-1:0][STATE_WIDTH-1:0] way_state;

  assign busy      = (fsm_q == S_SWEEP);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready;
  assign wr_ok     = w_en && !busy;

  // The sweep owns every way's write port while it runs.
  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    instr_state_tag_way #(
      .SET_WIDTH(SET_WIDTH), .TAG_WIDTH(TAG_WIDTH), .STATE_WIDTH(STATE_WIDTH)
    ) u_way (
      .clk   (clk),
      .we    (busy || (wr_ok && w_way[g])),
      .wset  (busy ? cnt_q : w_set),
      .wdata (busy ? {ST_I, {TAG_WIDTH{1'b0}}} : w_state_tag),
      .rset  (req_set),
      .rtag  (req_tag),
      .hit   (way_hit[g]),
      .inval (way_inval[g]),
      .state (way_state[g])
    );
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) fsm_d = S_IDLE;
      end
      default: begin
        if (inv_all) begin
          fsm_d = S_SWEEP;
          cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (wr_ok && w_fill)
      ptr_d[w_set] = PTR_W'((int'(ptr_q[w_set]) + 1) % NUM_WAYS);
  end

  // Hit and victim share the same read; duplicate hits resolve to the lowest way.
  always_comb begin
    logic hfound, vfound;
    rsp_t nxt;
    hfound      = 1'b0;
    vfound      = 1'b0;
    nxt.hit     = 1'b0;
    nxt.hit_way = '0;
    nxt.state   = ST_I;
    nxt.victim  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w] && !hfound) begin
        hfound         = 1'b1;
        nxt.hit        = 1'b1;
        nxt.hit_way[w] = 1'b1;
        nxt.state      = way_state[w];
      end
      if (way_inval[w] && !vfound) begin
        vfound        = 1'b1;
        nxt.victim[w] = 1'b1;
      end
    end
    if (!vfound) begin
      for (int w = 0; w < NUM_WAYS; w++)
        nxt.victim[w] = (ptr_q[req_set] == PTR_W'(w));
    end
    rsp_d       = accept ? nxt : rsp_q;
    rsp_valid_d = accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_SWEEP;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '{hit: 1'b0, hit_way: '0, state: ST_I, victim: '0};
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_q.hit;
  assign rsp_hit_way    = rsp_q.hit_way;
  assign rsp_state      = rsp_q.state;
  assign rsp_victim_way = rsp_q.victim;
endmodule

// File: tb/tb_instr_state_tag_array.sv
// Directed bench for instr_state_tag_array: sweep timing, hit/victim selection,
// replacement pointer, collision behaviour, flash invalidate and mid-sweep reset.

module tb_instr_state_tag_array;
  localparam int SW = 4, TW = 22, STW = 2, NW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [SW-1:0]   req_set = '0;
  logic [TW-1:0]   req_tag = '0;
  logic            rsp_valid, rsp_hit;
  logic [NW-1:0]   rsp_hit_way, rsp_victim_way;
  logic [STW-1:0]  rsp_state;
  logic            w_en = 1'b0, w_fill = 1'b0;
  logic [SW-1:0]   w_set = '0;
  logic [NW-1:0]   w_way = '0;
  logic [STW+TW-1:0] w_state_tag = '0;
  logic            inv_all = 1'b0;
  logic            busy;

  int nvec = 0;
  int nerr = 0;

  instr_state_tag_array #(.SET_WIDTH(SW), .TAG_WIDTH(TW), .STATE_WIDTH(STW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way),
    .rsp_state(rsp_state), .rsp_victim_way(rsp_victim_way),
    .w_en(w_en), .w_fill(w_fill), .w_set(w_set), .w_way(w_way), .w_state_tag(w_state_tag),
    .inv_all(inv_all), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [SW-1:0] s, input logic [NW-1:0] way,
                    input logic [STW-1:0] st, input logic [TW-1:0] t, input logic fill);
    w_en = 1'b1; w_set = s; w_way = way; w_state_tag = {st, t}; w_fill = fill;
    step();
    w_en = 1'b0; w_fill = 1'b0;
  endtask

  task automatic look(input string tag, input logic [SW-1:0] s, input logic [TW-1:0] t,
                      input logic eh, input logic [NW-1:0] ew, input logic [STW-1:0] es,
                      input logic [NW-1:0] ev);
    req_valid = 1'b1; req_set = s; req_tag = t;
    chk({tag, ".ready"}, 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
    chk({tag, ".valid"},  32'(rsp_valid), 32'h1);
    chk({tag, ".hit"},    32'(rsp_hit), 32'(eh));
    chk({tag, ".way"},    32'(rsp_hit_way), 32'(ew));
    chk({tag, ".state"},  32'(rsp_state), 32'(es));
    chk({tag, ".victim"}, 32'(rsp_victim_way), 32'(ev));
  endtask

  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  // A multi-way hit would mean a corrupted tag array.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      nvec++;
      assert ($onehot0(rsp_hit_way)) else begin
        nerr++;
        $error("FAIL onehot_hit: observed %0h expected at most one bit", rsp_hit_way);
      end
    end
  end

  initial begin
    int  n;
    logic seen_v;

    step(); step();
    chk("rst.busy",   32'(busy), 32'h1);
    chk("rst.ready",  32'(req_ready), 32'h0);
    chk("rst.valid",  32'(rsp_valid), 32'h0);
    chk("rst.hit",    32'(rsp_hit), 32'h0);
    chk("rst.way",    32'(rsp_hit_way), 32'h0);
    chk("rst.state",  32'(rsp_state), 32'h2);
    chk("rst.victim", 32'(rsp_victim_way), 32'h0);

    rst_n = 1'b1;
    count_sweep("init_sweep_len");

    look("empty0", 4'd0, 22'h0, 1'b0, 4'b0000, 2'b10, 4'b0001);
    step();
    chk("hold.valid",  32'(rsp_valid), 32'h0);
    chk("hold.victim", 32'(rsp_victim_way), 32'h1);
    look("empty14", 4'd14, 22'h3FFFFF, 1'b0, 4'b0000, 2'b10, 4'b0001);

    wr(4'd3, 4'b0100, 2'b01, 22'h2AB, 1'b1);
    look("s3hit", 4'd3, 22'h2AB, 1'b1, 4'b0100, 2'b01, 4'b0001);

    for (int i = 0; i < 4; i++)
      wr(4'd5, 4'(1 << i), 2'b01, 22'h100 + 22'(i), 1'b1);
    look("s5full_miss", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0001);
    look("s5hit2",      4'd5, 22'h102, 1'b1, 4'b0100, 2'b01, 4'b0001);
    wr(4'd5, 4'b0001, 2'b01, 22'h100, 1'b1);
    look("s5ptr1", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0010);
    for (int i = 0; i < 4; i++)
      wr(4'd5, 4'b0001, 2'b01, 22'h100, 1'b1);
    look("s5wrap", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0010);

    wr(4'd5, 4'b0100, 2'b10, 22'h102, 1'b0);
    look("s5inv_first", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0100);
    look("s5inv_nohit", 4'd5, 22'h102, 1'b0, 4'b0000, 2'b10, 4'b0100);
    wr(4'd5, 4'b0100, 2'b01, 22'h102, 1'b0);
    look("s5ptr_kept", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0010);

    // Same-cycle write and lookup: the lookup sees the old (invalid) entry.
    w_en = 1'b1; w_set = 4'd7; w_way = 4'b0010; w_state_tag = {2'b01, 22'h77}; w_fill = 1'b0;
    look("s7coll", 4'd7, 22'h77, 1'b0, 4'b0000, 2'b10, 4'b0001);
    w_en = 1'b0;
    look("s7after", 4'd7, 22'h77, 1'b1, 4'b0010, 2'b01, 4'b0001);
    step();
    chk("hold2.valid", 32'(rsp_valid), 32'h0);
    chk("hold2.hit",   32'(rsp_hit), 32'h1);
    chk("hold2.way",   32'(rsp_hit_way), 32'h2);

    // Flash invalidate with writes, lookups and a second inv_all thrown at it.
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    chk("inv.busy", 32'(busy), 32'h1);
    w_en = 1'b1; w_set = 4'd9; w_way = 4'b0001; w_state_tag = {2'b01, 22'h99}; w_fill = 1'b1;
    req_valid = 1'b1; req_set = 4'd9; req_tag = 22'h99;
    chk("inv.ready", 32'(req_ready), 32'h0);
    n = 0;
    seen_v = 1'b0;
    while (busy && n < 40) begin
      inv_all = (n == 8);
      step();
      n++;
      if (rsp_valid) seen_v = 1'b1;
    end
    inv_all = 1'b0; w_en = 1'b0; w_fill = 1'b0; req_valid = 1'b0;
    chk("inv_sweep_len", 32'(n), 32'd16);
    chk("inv_no_rsp",    32'(seen_v), 32'h0);

    look("inv_s3", 4'd3, 22'h2AB, 1'b0, 4'b0000, 2'b10, 4'b0001);
    look("inv_s5", 4'd5, 22'h100, 1'b0, 4'b0000, 2'b10, 4'b0001);
    look("inv_s7", 4'd7, 22'h77,  1'b0, 4'b0000, 2'b10, 4'b0001);
    look("inv_s9", 4'd9, 22'h99,  1'b0, 4'b0000, 2'b10, 4'b0001);

    wr(4'd12, 4'b0001, 2'b01, 22'hC0, 1'b0);
    look("s12hit", 4'd12, 22'hC0, 1'b1, 4'b0001, 2'b01, 4'b0010);

    // Reset in the middle of a sweep, before set 12 is reached.
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid.busy",   32'(busy), 32'h1);
    chk("mid.ready",  32'(req_ready), 32'h0);
    chk("mid.valid",  32'(rsp_valid), 32'h0);
    chk("mid.hit",    32'(rsp_hit), 32'h0);
    chk("mid.way",    32'(rsp_hit_way), 32'h0);
    chk("mid.state",  32'(rsp_state), 32'h2);
    chk("mid.victim", 32'(rsp_victim_way), 32'h0);
    step(); step();
    rst_n = 1'b1;
    count_sweep("post_rst_sweep_len");
    look("s12gone", 4'd12, 22'hC0, 1'b0, 4'b0000, 2'b10, 4'b0001);

    // Replacement pointers restart at 0 after reset.
    for (int i = 0; i < 4; i++)
      wr(4'd5, 4'(1 << i), 2'b00, 22'h200 + 22'(i), 1'b0);
    look("s5ptr_rst", 4'd5, 22'h3FF, 1'b0, 4'b0000, 2'b10, 4'b0001);
    look("s5dirty",   4'd5, 22'h203, 1'b1, 4'b1000, 2'b00, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/instr_state_tag_array.md
Name: instr_state_tag_array

Overview:
- N-way set-associative state-tag store for the I-Cache. Parametrised successor of the single-way direct-mapped state-tag RAM.
- Holds one {state, tag} entry per way per set.
- Performs a registered lookup with tag compare, reporting hit, hit way and a replacement victim way.
- Provides a hardware flash-invalidate sweep that runs after reset and on request.
- Sits between the I-Cache controller FSM and the data-array way select.

Parameters:
- SET_WIDTH, 4, set index width; 2**SET_WIDTH sets (addr[9:6]).
- TAG_WIDTH, 22, tag width (addr[31:10]).
- STATE_WIDTH, 2, state encoding: I=2'b10, C=2'b01, D=2'b00.
- NUM_WAYS, 4, associativity; power of 2, 1..8.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, lookup request.
- req_ready, out, 1, lookup accepted this cycle; equals !busy.
- req_set, in, SET_WIDTH, lookup set index.
- req_tag, in, TAG_WIDTH, lookup tag.
- rsp_valid, out, 1, lookup result valid; one cycle after acceptance.
- rsp_hit, out, 1, some valid way matched the tag.
- rsp_hit_way, out, NUM_WAYS, one-hot matching way; zero on miss.
- rsp_state, out, STATE_WIDTH, state of the hit way; 2'b10 on miss.
- rsp_victim_way, out, NUM_WAYS, one-hot way to fill on miss.
- w_en, in, 1, write one entry.
- w_fill, in, 1, write is a line fill; advances the set's replacement pointer.
- w_set, in, SET_WIDTH, write set index.
- w_way, in, NUM_WAYS, one-hot write way.
- w_state_tag, in, STATE_WIDTH+TAG_WIDTH, {state, tag} to write.
- inv_all, in, 1, start flash invalidate (pulse).
- busy, out, 1, sweep in progress.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_hit=0, rsp_hit_way=0, rsp_state=2'b10, rsp_victim_way=0, busy=1.
  - All replacement pointers cleared to 0; sweep counter = 0; FSM = SWEEP.
  - RAM contents are not reset directly; the sweep clears them.
- FSM states:
  - SWEEP: each cycle writes {2'b10, 0} to every way of set cnt, then cnt++. After set 2**SET_WIDTH-1 is written, go to IDLE. Duration is exactly 2**SET_WIDTH cycles; busy=1 throughout.
  - IDLE: busy=0. If inv_all=1, go to SWEEP with cnt=0 next cycle, and busy=1 from the next cycle. inv_all while already in SWEEP is ignored; the sweep does not restart.
- Lookup:
  - Accepted when req_valid && req_ready.
  - Set is read synchronously; compare and results are registered; rsp_valid=1 exactly 1 cycle later.
  - rsp_valid=0 otherwise; other rsp_* outputs hold their last values.
  - A way hits when tag == req_tag and state != 2'b10.
  - If more than one way hits (illegal), report the lowest index. The bench asserts this never occurs.
- Victim selection:
  - Lowest-index way with state I.
  - If no way is invalid, the way at the set's round-robin pointer.
  - Computed from the same read data as the hit compare.
- Write:
  - w_en ignored while busy.
  - Writes every way whose w_way bit is set; normal use is one-hot.
  - If w_fill=1, that set's pointer becomes (pointer+1) mod NUM_WAYS, independent of which way was written.
- Read/write collision: lookup and write to the same set in the same cycle → the lookup returns pre-write (old) data.
- Reset asserted mid-sweep or mid-lookup: everything aborts immediately; a full sweep restarts on deassertion.
- NUM_WAYS=1: victim is always way 0; the pointer is unused.

Test Plan:
- Release reset: busy=1 for exactly 16 cycles, then req_ready=1. A lookup of any set returns rsp_hit=0, rsp_victim_way=4'b0001.
- Write set 3, way 4'b0100, {01, 22'h2AB} with w_fill=1, then look up set 3 tag 22'h2AB → next cycle rsp_valid=1, rsp_hit=1, rsp_hit_way=4'b0100, rsp_state=2'b01.
- Fill all 4 ways of set 5 with valid tags using w_fill → pointer=0. Lookup of a missing tag → victim 4'b0001. One more fill → victim 4'b0010. After 4 more fills the pointer wraps back to the same way.
- Set 5 full; write way 2 to {10, x} with w_fill=0 → victim 4'b0100 (invalid-first wins), pointer unchanged.
- Same-cycle write and lookup of set 7 with the same tag, entry previously invalid → rsp_hit=0. Repeating the lookup one cycle later → rsp_hit=1.
- Pulse inv_all from IDLE → busy=1 for 16 cycles, w_en and req_valid ignored during the sweep, all previous hits now miss. Assert rst_n=0 at sweep cycle 5 → outputs at reset values immediately, and a full 16-cycle sweep occurs after release.
